// File: rtl/rom_stream_reader.sv
// Streams a run of consecutive ROM words (wrapping at ADDR_MAX) onto a valid/ready
// interface, buffering at most two words so a stalling consumer never loses data.
module rom_stream_reader #(
  parameter int ADDR_MAX   = 123,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  rom_vld_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  logic                  push, pop, issue;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(ADDR_MAX - 1))
      return '0;
    else
      return a + 1'b1;
  endfunction

  assign o_rom_addr = addr_p0;
  assign o_valid    = (fifo_count != 2'd0);
  assign o_data     = o_valid ? fifo_mem[rd_ptr] : '0;
  assign pop        = o_valid & i_ready;
  assign push       = rom_vld_p1;

  // Occupancy seen by this cycle's issue decision: buffered + in flight - leaving now.
  assign occ   = 3'(fifo_count) + 3'(rom_vld_p1) - 3'(pop);
  assign issue = (state == RUN) && (remaining != '0) && (occ < 3'd2);

  always_comb begin
    state_nxt = state;
    o_busy    = (state != IDLE);
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start)
          state_nxt = (i_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (issue && remaining == LEN_WIDTH'(1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the last word is being taken, so o_done follows it directly.
        if (!rom_vld_p1 && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
          state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: address issue; stage p1: ROM data returning, pushed into the FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      addr_p0    <= '0;
      remaining  <= '0;
      rom_vld_p1 <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      state      <= state_nxt;
      rom_vld_p1 <= issue;
      if (state == IDLE && i_start) begin
        addr_p0   <= i_base_addr;
        remaining <= i_len;
      end else if (issue) begin
        addr_p0   <= next_addr(addr_p0);
        remaining <= remaining - 1'b1;
      end
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Stage p1 -> FIFO storage: data path carries no reset.
  always_ff @(posedge i_clk) begin
    if (push)
      fifo_mem[wr_ptr] <= i_rom_data;
  end

endmodule
